program_loader: RTL and testbench

Writer side of the CPU's instruction-fetch path. Accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit instruction words, and writes them into instruction memory at consecutive even byte addresses starting at 0. Holds the CPU stalled until a complete program, terminated by the halt word 16'hFFFF, has been written. Sits between an external host/stream source and the write port of InstructionMemory.

---
 rtl/program_loader.sv | 112 +++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction-memory writer: packs a big-endian byte stream into 16-bit words
// and stalls the CPU until a program ending in the halt word has been stored.
module program_loader #(
  parameter int DEPTH_WORDS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [15:0] HALT_WORD  = 16'hFFFF;
  localparam logic [15:0] LAST_COUNT = 16'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] count_q, count_d;

  // Next-state and datapath update for the load sequencer
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = HI;
          addr_d  = 16'd0;
          count_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      HI: begin
        if (in_valid) begin
          wdata_d = {in_data, wdata_q[7:0]};
          state_d = LO;
        end else begin
          state_d = HI;
        end
      end
      LO: begin
        if (in_valid) begin
          wdata_d = {wdata_q[15:8], in_data};
          state_d = WRITE;
        end else begin
          state_d = LO;
        end
      end
      WRITE: begin
        count_d = count_q + 16'd1;
        // Halt check wins over the capacity check so a halt in the last slot succeeds
        if (wdata_q == HALT_WORD) begin
          state_d = DONE;
        end else if (count_d == LAST_COUNT) begin
          state_d = ERROR;
        end else begin
          addr_d  = addr_q + 16'd2;
          state_d = HI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  assign in_ready   = (state_q == HI) || (state_q == LO);
  assign mem_we     = (state_q == WRITE);
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: a default-depth instance
// for load/restart/backpressure/reset cases and a 4-word instance for overflow.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset, start, start4, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, done, error;
  logic [15:0] mem_addr, mem_wdata, word_count;
  logic        in_ready4, mem_we4, cpu_hold4, done4, error4;
  logic [15:0] mem_addr4, mem_wdata4, word_count4;

  int checks = 0;
  int errors = 0;

  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  logic [15:0] log4_addr[$];
  logic [15:0] log4_data[$];

  program_loader #(.DEPTH_WORDS(128)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  program_loader #(.DEPTH_WORDS(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .cpu_hold(cpu_hold4), .done(done4), .error(error4), .word_count(word_count4)
  );

  always #5 clock = ~clock;

  // Record every memory write seen mid-cycle
  always @(negedge clock) begin
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (mem_we4) begin
      log4_addr.push_back(mem_addr4);
      log4_data.push_back(mem_wdata4);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the selected loader accepts it
  task automatic send_byte(input logic [7:0] b, input logic sel, input logic gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (((sel ? in_ready4 : in_ready) !== 1'b1) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq("handshake_timeout", 32'(n < 50), 32'd1);
    @(negedge clock);
  endtask

  task automatic pulse_start(input logic sel);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_log(input string tag, input logic [15:0] ea[$], input logic [15:0] ed[$]);
    check_eq({tag, "_nwrites"}, 32'(log_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < log_addr.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(ea[i]));
      check_eq($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), 32'(ed[i]));
    end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input logic gap);
    foreach (bytes[i]) send_byte(bytes[i], 1'b0, gap);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start4 = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_reset_state("por");

    // Pending byte in IDLE without start must not be taken
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clock);
    check_eq("idle_no_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Basic load
    log_addr.delete(); log_data.delete();
    pulse_start(1'b0);
    check_eq("start_ready", 32'(in_ready), 32'd1);
    send_stream('{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF}, 1'b0);
    wait_done("basic_done");
    check_log("basic", '{16'd0, 16'd2, 16'd4}, '{16'h1234, 16'h5678, 16'hFFFF});
    check_eq("basic_hold", 32'(cpu_hold), 32'd0);
    check_eq("basic_count", 32'(word_count), 32'd3);
    check_eq("basic_error", 32'(error), 32'd0);
    check_eq("basic_ready", 32'(in_ready), 32'd0);

    // Restart after done
    log_addr.delete(); log_data.delete();
    pulse_start(1'b0);
    check_eq("restart_done_clr", 32'(done), 32'd0);
    check_eq("restart_hold", 32'(cpu_hold), 32'd1);
    check_eq("restart_count0", 32'(word_count), 32'd0);
    send_stream('{8'h00, 8'h01, 8'hFF, 8'hFF}, 1'b0);
    wait_done("restart_done");
    check_log("restart", '{16'd0, 16'd2}, '{16'h0001, 16'hFFFF});
    check_eq("restart_count", 32'(word_count), 32'd2);

    // Backpressure: gaps between every byte
    log_addr.delete(); log_data.delete();
    pulse_start(1'b0);
    send_byte(8'h12, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("gap_hi_only_nowrite", 32'(log_addr.size()), 32'd0);
    check_eq("gap_stall_ready", 32'(in_ready), 32'd1);
    send_stream('{8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF}, 1'b1);
    wait_done("gap_done");
    check_log("gap", '{16'd0, 16'd2, 16'd4}, '{16'h1234, 16'h5678, 16'hFFFF});
    check_eq("gap_count", 32'(word_count), 32'd3);

    // Start pulsed while in LO is ignored
    log_addr.delete(); log_data.delete();
    pulse_start(1'b0);
    send_stream('{8'h12, 8'h34, 8'h56}, 1'b0);
    pulse_start(1'b0);
    check_eq("ign_addr", 32'(mem_addr), 32'd2);
    send_stream('{8'h78, 8'hFF, 8'hFF}, 1'b0);
    wait_done("ign_done");
    check_log("ign", '{16'd0, 16'd2, 16'd4}, '{16'h1234, 16'h5678, 16'hFFFF});

    // Reset asserted during WRITE
    pulse_start(1'b0);
    send_stream('{8'hAB, 8'hCD}, 1'b0);
    check_eq("rst_in_write_we", 32'(mem_we), 32'd1);
    check_eq("rst_in_write_data", 32'(mem_wdata), 32'hABCD);
    in_valid = 1'b1; in_data = 8'h11;
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_we_suppressed", 32'(mem_we), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    check_reset_state("midrst");
    @(negedge clock);
    check_eq("midrst_idle_ready", 32'(in_ready), 32'd0);

    // Overflow on the 4-word instance
    pulse_start(1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'h00, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("ovf_nwrites", 32'(log4_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log4_addr.size(); i++) begin
      check_eq($sformatf("ovf_addr%0d", i), 32'(log4_addr[i]), 32'(2 * i));
      check_eq($sformatf("ovf_data%0d", i), 32'(log4_data[i]), 32'd0);
    end
    check_eq("ovf_error", 32'(error4), 32'd1);
    check_eq("ovf_hold", 32'(cpu_hold4), 32'd1);
    check_eq("ovf_ready", 32'(in_ready4), 32'd0);
    check_eq("ovf_done", 32'(done4), 32'd0);
    check_eq("ovf_count", 32'(word_count4), 32'd4);
    pulse_start(1'b1);
    check_eq("ovf_restart_err_clr", 32'(error4), 32'd0);
    check_eq("ovf_restart_ready", 32'(in_ready4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
